fetch_ctrl: RTL and testbench

- Sequences instruction fetch: owns the PC, issues word-addressed requests to instruction memory and delivers instruction/PC pairs to decode over a valid/ready handshake.
- Handles branch redirects. Redirected requests already in flight are squashed, using an epoch bit.
- Sits between the instruction memory and decode, and replaces the free-running PC/offset path.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_outbuf.sv | 37 +++
 rtl/fetch_ctrl.sv | 125 ++++++++++++
 tb/tb_fetch_ctrl.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encodings,
// reset PC default and the branch-target helper. Optional build macro: FETCH_PERF_EN.
package fetch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_HOLD = 2'd3;

  localparam logic [63:0] RESET_PC_DEF = 64'd0;

  // Wide enough for any supported address width; callers truncate the result.
  localparam int TGT_W = 64;

  function automatic logic [TGT_W-1:0] next_target(input logic [TGT_W-1:0] pc,
                                                   input logic [TGT_W-1:0] offset);
    return pc + (offset << 1);
  endfunction

endpackage

// File: rtl/fetch_outbuf.sv
// Single-entry (instr, pc) holding register between fetch and decode.
// Flush drops the entry regardless of ready; contents are stable while stalled.
module fetch_outbuf
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_instr,
  input  logic [ADDR_W-1:0] wr_pc,
  input  logic              flush,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (wr_en) begin
      valid <= 1'b1;
      instr <= wr_instr;
      pc    <= wr_pc;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one outstanding imem request at a
// time and squashes redirected responses via an epoch bit. Optional macro: FETCH_PERF_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF[ADDR_W-1:0]
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic              stall
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, req_pc, br_target;
  logic              epoch, req_epoch;
  logic              br_act, buf_free, issue, fresh;

  logic [TGT_W-1:0]        br_pc_ext, br_off_ext, target_ext;
  logic [TGT_W-ADDR_W-1:0] unused_tgt_hi;

  assign br_pc_ext     = TGT_W'(br_pc);
  assign br_off_ext    = TGT_W'(br_offset);
  assign target_ext    = next_target(br_pc_ext, br_off_ext);
  assign br_target     = target_ext[ADDR_W-1:0];
  assign unused_tgt_hi = target_ext[TGT_W-1:ADDR_W];

  assign br_act   = br_taken && (state != ST_IDLE);
  assign buf_free = !if_valid || if_ready;
  // A redirect in REQ suppresses the request so the old PC is never fetched.
  assign issue    = (state == ST_REQ) && !stall && buf_free && !br_taken;
  assign fresh    = (state == ST_WAIT) && imem_rvalid && !br_taken && (req_epoch == epoch);

  assign imem_req  = issue;
  assign imem_addr = issue ? pc : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ: begin
        if (br_act)                   state_nxt = ST_REQ;
        else if (issue)               state_nxt = ST_WAIT;
        else if (!stall && !buf_free) state_nxt = ST_HOLD;
      end
      ST_WAIT: begin
        if (imem_rvalid) state_nxt = (br_act || buf_free) ? ST_REQ : ST_HOLD;
      end
      ST_HOLD: begin
        if (br_act || buf_free) state_nxt = ST_REQ;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      epoch     <= 1'b0;
      req_pc    <= '0;
      req_epoch <= 1'b0;
    end else begin
      state <= state_nxt;
      if (br_act) begin
        pc    <= br_target;
        epoch <= ~epoch;
      end else if (fresh) begin
        pc <= req_pc + ADDR_W'(1);
      end
      if (issue) begin
        req_pc    <= pc;
        req_epoch <= epoch;
      end
    end
  end

  fetch_outbuf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_outbuf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (fresh),
    .wr_instr (imem_rdata),
    .wr_pc    (req_pc),
    .flush    (br_act),
    .ready    (if_ready),
    .valid    (if_valid),
    .instr    (if_instr),
    .pc       (if_pc)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if ((stall || state == ST_HOLD) && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (br_taken && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: expected (pc, instr) transfers are queued as stimulus
// is driven and compared at each decode handshake; a latency-configurable memory responds.
module tb_fetch_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  logic        clk, rst;
  logic        imem_req, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic        br_taken, stall;
  logic [31:0] br_pc, br_offset;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int    n_total = 0;
  int    n_bad   = 0;
  int    hs_cnt  = 0;
  int    mem_lat = 1;
  int    ncyc    = 0;
  item_t sb_q[$];
  item_t mon_item;
  int    due_q[$];
  logic [31:0] maddr_q[$];

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .br_taken    (br_taken),
    .br_pc       (br_pc),
    .br_offset   (br_offset),
    .stall       (stall)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + a * 32'd3;
  endfunction

  task automatic push_exp(input logic [31:0] pc);
    item_t it;
    it.pc    = pc;
    it.instr = mem_word(pc);
    sb_q.push_back(it);
  endtask

  // Memory: requests seen in cycle n answer in cycle n + mem_lat.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (imem_req === 1'b1) begin
        due_q.push_back(ncyc + mem_lat);
        maddr_q.push_back(imem_addr);
      end
      @(posedge clk);
      #1;
      if (due_q.size() > 0 && due_q[0] == ncyc + 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(maddr_q[0]);
        void'(due_q.pop_front());
        void'(maddr_q.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && if_valid === 1'b1 && if_ready === 1'b1) begin
      hs_cnt++;
      n_total++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_hs: got pc=%h instr=%h, required no transfer", if_pc, if_instr);
      end else begin
        mon_item = sb_q.pop_front();
        if (if_pc !== mon_item.pc || if_instr !== mon_item.instr) begin
          n_bad++;
          $display("FAIL hs_data: got pc=%h instr=%h, required pc=%h instr=%h",
                   if_pc, if_instr, mon_item.pc, mon_item.instr);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int max_cyc, output logic [31:0] addr, output bit ok);
    ok   = 1'b0;
    addr = '0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        ok   = 1'b1;
        addr = imem_addr;
      end
    end
  endtask

  task automatic wait_drain(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; if_ready = 1'b1; br_taken = 1'b0; stall = 1'b0;
    br_pc = '0; br_offset = '0;
    repeat (3) @(negedge clk);
    n_total++;
    if (if_valid !== 1'b0 || if_instr !== 32'd0 || if_pc !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_outbuf: got v=%b instr=%h pc=%h, required 0/0/0", if_valid, if_instr, if_pc);
    end
    n_total++;
    if (imem_req !== 1'b0 || imem_addr !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_imem: got req=%b addr=%h, required 0/0", imem_req, imem_addr);
    end
`ifdef FETCH_PERF_EN
    n_total++;
    if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_perf: got %0d/%0d, required 0/0", perf_stall_cnt, perf_flush_cnt);
    end
`endif
    step();
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    bit ok;
    mem_lat = 1;
    for (int i = 0; i < 4; i++) push_exp(i);
    for (int i = 0; i < 4; i++) begin
      wait_req(20, a, ok);
      n_total++;
      if (!ok || a !== 32'(i)) begin
        n_bad++;
        $display("FAIL seq_addr%0d: got ok=%b addr=%h, required addr=%h", i, ok, a, i);
      end
    end
    step();
    stall = 1'b1;
    wait_drain(20, ok);
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL seq_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    bit ok;
    int hs0;
    step();
    if_ready = 1'b0;
    stall    = 1'b0;
    push_exp(32'd4);
    wait_req(20, a, ok);
    n_total++;
    if (!ok || a !== 32'd4) begin
      n_bad++;
      $display("FAIL bp_addr: got ok=%b addr=%h, required 4", ok, a);
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (if_valid === 1'b1) ok = 1'b1;
    end
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (if_valid !== 1'b1 || if_pc !== 32'd4 || if_instr !== mem_word(32'd4) || imem_req !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got v=%b pc=%h instr=%h req=%b, required 1/%h/%h/0",
                 i, if_valid, if_pc, if_instr, imem_req, 32'd4, mem_word(32'd4));
      end
      @(negedge clk);
    end
    hs0 = hs_cnt;
    step();
    if_ready = 1'b1;
    stall    = 1'b1;
    repeat (4) @(negedge clk);
    n_total++;
    if (hs_cnt - hs0 != 1 || if_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: got %0d handshakes v=%b, required 1 and v=0", hs_cnt - hs0, if_valid);
    end
  endtask

  task automatic test_branch_stale();
    logic [31:0] a;
    bit ok;
    mem_lat = 4;
    step();
    stall = 1'b0;
    wait_req(20, a, ok);
    n_total++;
    if (!ok || a !== 32'd5) begin
      n_bad++;
      $display("FAIL brs_first: got ok=%b addr=%h, required 5", ok, a);
    end
    step();
    br_taken = 1'b1; br_pc = 32'd8; br_offset = 32'd3;
    push_exp(32'd14);
    step();
    br_taken = 1'b0;
    wait_req(20, a, ok);
    n_total++;
    if (!ok || a !== 32'd14) begin
      n_bad++;
      $display("FAIL brs_target: got ok=%b addr=%h, required %h", ok, a, 32'd14);
    end
    step();
    stall = 1'b1;
    wait_drain(30, ok);
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL brs_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_branch_rvalid();
    logic [31:0] a;
    bit ok;
    mem_lat = 2;
    step();
    stall = 1'b0;
    wait_req(20, a, ok);
    n_total++;
    if (!ok || a !== 32'd15) begin
      n_bad++;
      $display("FAIL brr_first: got ok=%b addr=%h, required %h", ok, a, 32'd15);
    end
    step();
    step();
    br_taken = 1'b1; br_pc = 32'd40; br_offset = 32'hFFFF_FFFE;
    push_exp(32'd36);
    @(negedge clk);
    n_total++;
    if (imem_rvalid !== 1'b1) begin
      n_bad++;
      $display("FAIL brr_align: got rvalid=%b with br_taken, required 1", imem_rvalid);
    end
    step();
    br_taken = 1'b0;
    wait_req(20, a, ok);
    n_total++;
    if (!ok || a !== 32'd36) begin
      n_bad++;
      $display("FAIL brr_target: got ok=%b addr=%h, required %h", ok, a, 32'd36);
    end
    step();
    stall = 1'b1;
    wait_drain(30, ok);
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL brr_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_stall_wait();
    logic [31:0] a;
    bit ok;
    mem_lat = 4;
    step();
    stall = 1'b0;
    push_exp(32'd37);
    push_exp(32'd38);
    wait_req(20, a, ok);
    n_total++;
    if (!ok || a !== 32'd37) begin
      n_bad++;
      $display("FAIL stw_first: got ok=%b addr=%h, required %h", ok, a, 32'd37);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      stall = 1'b1;
      @(negedge clk);
      n_total++;
      if (imem_req !== 1'b0) begin
        n_bad++;
        $display("FAIL stw_noreq%0d: got req=%b, required 0", i, imem_req);
      end
    end
    step();
    stall = 1'b0;
    wait_req(20, a, ok);
    n_total++;
    if (!ok || a !== 32'd38) begin
      n_bad++;
      $display("FAIL stw_next: got ok=%b addr=%h, required %h", ok, a, 32'd38);
    end
    step();
    stall = 1'b1;
    wait_drain(30, ok);
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL stw_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_wrap();
    logic [31:0] a;
    bit ok;
    mem_lat = 1;
    step();
    stall = 1'b0;
    wait_req(20, a, ok);
    step();
    br_taken = 1'b1; br_pc = 32'd1; br_offset = 32'h7FFF_FFFF;
    push_exp(32'hFFFF_FFFF);
    push_exp(32'd0);
    step();
    br_taken = 1'b0;
    wait_req(20, a, ok);
    n_total++;
    if (!ok || a !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL wrap_target: got ok=%b addr=%h, required ffffffff", ok, a);
    end
    wait_req(20, a, ok);
    n_total++;
    if (!ok || a !== 32'd0) begin
      n_bad++;
      $display("FAIL wrap_zero: got ok=%b addr=%h, required 0", ok, a);
    end
    step();
    stall = 1'b1;
    wait_drain(30, ok);
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL wrap_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] a;
    bit ok;
    mem_lat = 3;
    step();
    stall = 1'b0;
    wait_req(20, a, ok);
    n_total++;
    if (!ok || a !== 32'd1) begin
      n_bad++;
      $display("FAIL rmw_first: got ok=%b addr=%h, required 1", ok, a);
    end
    step();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_total++;
      if (if_valid !== 1'b0 || if_instr !== 32'd0 || if_pc !== 32'd0 ||
          imem_req !== 1'b0 || imem_addr !== 32'd0) begin
        n_bad++;
        $display("FAIL rmw_resetval%0d: got v=%b instr=%h pc=%h req=%b addr=%h, required all 0",
                 i, if_valid, if_instr, if_pc, imem_req, imem_addr);
      end
`ifdef FETCH_PERF_EN
      n_total++;
      if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
        n_bad++;
        $display("FAIL rmw_perf%0d: got %0d/%0d, required 0/0", i, perf_stall_cnt, perf_flush_cnt);
      end
`endif
      if (i == 0) step();
    end
    step();
    rst = 1'b0;
    push_exp(32'd0);
    @(negedge clk);
    n_total++;
    if (imem_rvalid !== 1'b1 || if_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL rmw_idle: got rvalid=%b v=%b req=%b, required 1/0/0", imem_rvalid, if_valid, imem_req);
    end
    @(negedge clk);
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      n_bad++;
      $display("FAIL rmw_restart: got req=%b addr=%h, required 1/0", imem_req, imem_addr);
    end
    step();
    stall = 1'b1;
    wait_drain(30, ok);
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL rmw_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_branch_stale();
    test_branch_rvalid();
    test_stall_wait();
    test_wrap();
    test_reset_mid_wait();
    repeat (5) @(negedge clk);
    n_total++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL final_sb: got %0d pending, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
